// File: rtl/mem_access_master_if.sv
// Purpose: command / write-data / response / memory-port bundle for mem_access_master.
// Latency: none; wires only.
// Backpressure: cmd and wdata use valid/ready, rsp uses valid/ready, memory port is fire-and-forget.
// Ports: master = initiator view (drives cmd_ready, wdata_ready, rsp_*, stray_err, mem_*);
//        slave  = client + memory view (drives cmd_*, wdata*, rsp_ready, mem_data_out, mem_valid_out).
interface mem_access_master_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 4
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_wr;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [LEN_WIDTH-1:0]  cmd_len;
  logic                  wdata_valid;
  logic                  wdata_ready;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_last;
  logic                  rsp_err;
  logic                  stray_err;
  logic                  mem_en;
  logic                  mem_wr;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_data_in;
  logic [DATA_WIDTH-1:0] mem_data_out;
  logic                  mem_valid_out;

  modport master (
    input  cmd_valid, cmd_wr, cmd_addr, cmd_len, wdata_valid, wdata, rsp_ready,
           mem_data_out, mem_valid_out,
    output cmd_ready, wdata_ready, rsp_valid, rsp_rdata, rsp_last, rsp_err, stray_err,
           mem_en, mem_wr, mem_addr, mem_data_in
  );

  modport slave (
    output cmd_valid, cmd_wr, cmd_addr, cmd_len, wdata_valid, wdata, rsp_ready,
           mem_data_out, mem_valid_out,
    input  cmd_ready, wdata_ready, rsp_valid, rsp_rdata, rsp_last, rsp_err, stray_err,
           mem_en, mem_wr, mem_addr, mem_data_in
  );
endinterface

// File: rtl/mem_access_master.sv
// Purpose: burst initiator for a simple memory port; one access per beat, address wraps at DEPTH.
// Latency: write ack 1 cycle after last beat; read rsp follows mem_valid_out by 1 cycle (or TIMEOUT).
// Backpressure: a held response stalls the next read issue; cmd/wdata ready drop while busy.
// Ports: clk, rst (sync, active-high); bus (mem_access_master_if.master) carries cmd, wdata, rsp
//        streams, the sticky stray_err flag, and the memory port (mem_en/wr/addr/data_in, data_out/valid_out).
module mem_access_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int LEN_WIDTH  = 4,
  parameter int TIMEOUT    = 15
) (
  input  logic                clk,
  input  logic                rst,
  mem_access_master_if.master bus
);

  typedef enum logic [2:0] {IDLE, WR_BEAT, RD_ISSUE, RD_WAIT, RSP} state_t;

  localparam int                    TMO_W     = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] DEPTH_A   = ADDR_WIDTH'(DEPTH);
  localparam logic [TMO_W-1:0]      TMO_LAST  = TMO_W'(TIMEOUT - 1);

  state_t                state;
  logic [ADDR_WIDTH-1:0] cur;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [LEN_WIDTH-1:0]  beat_cnt;
  logic [TMO_W-1:0]      tmo_cnt;

  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a);
    return (a == LAST_ADDR) ? '0 : a + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      cur             <= '0;
      len_q           <= '0;
      beat_cnt        <= '0;
      tmo_cnt         <= '0;
      bus.cmd_ready   <= 1'b0;
      bus.wdata_ready <= 1'b0;
      bus.rsp_valid   <= 1'b0;
      bus.rsp_rdata   <= '0;
      bus.rsp_last    <= 1'b0;
      bus.rsp_err     <= 1'b0;
      bus.stray_err   <= 1'b0;
      bus.mem_en      <= 1'b0;
      bus.mem_wr      <= 1'b0;
      bus.mem_addr    <= '0;
      bus.mem_data_in <= '0;
    end else begin
      // mem_en is a single-cycle strobe; the other mem_* outputs hold their last value.
      bus.mem_en <= 1'b0;

      // Read data arriving when no read is in flight means the memory misbehaved.
      if (bus.mem_valid_out && state != RD_WAIT && state != RD_ISSUE)
        bus.stray_err <= 1'b1;

      case (state)
        IDLE: begin
          bus.cmd_ready <= 1'b1;
          if (bus.cmd_valid && bus.cmd_ready) begin
            bus.cmd_ready <= 1'b0;
            len_q         <= bus.cmd_len;
            cur           <= bus.cmd_addr;
            beat_cnt      <= '0;
            if (bus.cmd_addr >= DEPTH_A) begin
              // Out-of-range start: answer with a single error, never touch memory.
              bus.rsp_valid <= 1'b1;
              bus.rsp_err   <= 1'b1;
              bus.rsp_last  <= 1'b1;
              bus.rsp_rdata <= '0;
              state         <= RSP;
            end else if (bus.cmd_wr) begin
              bus.wdata_ready <= 1'b1;
              state           <= WR_BEAT;
            end else begin
              state <= RD_ISSUE;
            end
          end
        end

        WR_BEAT: begin
          if (bus.wdata_valid && bus.wdata_ready) begin
            bus.mem_en      <= 1'b1;
            bus.mem_wr      <= 1'b1;
            bus.mem_addr    <= cur;
            bus.mem_data_in <= bus.wdata;
            cur             <= next_addr(cur);
            beat_cnt        <= beat_cnt + 1'b1;
            if (beat_cnt == len_q) begin
              bus.wdata_ready <= 1'b0;
              bus.rsp_valid   <= 1'b1;
              bus.rsp_err     <= 1'b0;
              bus.rsp_last    <= 1'b1;
              bus.rsp_rdata   <= '0;
              state           <= RSP;
            end
          end
        end

        RD_ISSUE: begin
          bus.mem_en   <= 1'b1;
          bus.mem_wr   <= 1'b0;
          bus.mem_addr <= cur;
          tmo_cnt      <= '0;
          state        <= RD_WAIT;
        end

        RD_WAIT: begin
          if (bus.mem_valid_out) begin
            bus.rsp_valid <= 1'b1;
            bus.rsp_rdata <= bus.mem_data_out;
            bus.rsp_err   <= 1'b0;
            bus.rsp_last  <= (beat_cnt == len_q);
            cur           <= next_addr(cur);
            beat_cnt      <= beat_cnt + 1'b1;
            state         <= RSP;
          end else if (tmo_cnt == TMO_LAST) begin
            // Memory never answered: report and abandon the rest of the burst.
            bus.rsp_valid <= 1'b1;
            bus.rsp_rdata <= '0;
            bus.rsp_err   <= 1'b1;
            bus.rsp_last  <= 1'b1;
            state         <= RSP;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end

        RSP: begin
          if (bus.rsp_valid && bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            if (bus.rsp_last) begin
              bus.cmd_ready <= 1'b1;
              state         <= IDLE;
            end else begin
              // Only read bursts produce non-last responses.
              state <= RD_ISSUE;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_master.sv
module tb_mem_access_master;
  localparam int AW = 32, DW = 32, LW = 4, DEPTH = 16, TIMEOUT = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_access_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) bus ();

  mem_access_master #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .LEN_WIDTH(LW), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        last;
    logic        err;
  } rsp_t;

  rsp_t        sb[$];
  rsp_t        e;
  int          n_checks = 0;
  int          n_pass   = 0;

  logic [31:0] mem_model[DEPTH];
  logic        log_wr[$];
  logic [31:0] log_addr[$];
  logic [31:0] log_data[$];
  bit          mute = 1'b0;
  int          inject_req = 0;
  int          rd_run = 0;
  int          rd_run_max = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  task automatic push_exp(input logic [31:0] rdata, input logic last, input logic err);
    rsp_t r;
    r.rdata = rdata;
    r.last  = last;
    r.err   = err;
    sb.push_back(r);
  endtask

  task automatic clear_log();
    log_wr.delete();
    log_addr.delete();
    log_data.delete();
  endtask

  // Memory model: 1-cycle read latency, optional silence, stray-valid injection.
  initial begin
    int inject_ack;
    inject_ack = 0;
    for (int i = 0; i < DEPTH; i++) mem_model[i] = 32'hD000_0000 | 32'(i);
    bus.mem_valid_out = 1'b0;
    bus.mem_data_out  = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.mem_valid_out = 1'b0;
      if (bus.mem_en) begin
        log_wr.push_back(bus.mem_wr);
        log_addr.push_back(bus.mem_addr);
        log_data.push_back(bus.mem_data_in);
        if (bus.mem_wr) begin
          mem_model[bus.mem_addr[3:0]] = bus.mem_data_in;
        end else if (!mute) begin
          bus.mem_valid_out = 1'b1;
          bus.mem_data_out  = mem_model[bus.mem_addr[3:0]];
        end
      end
      if (bus.mem_en && !bus.mem_wr) rd_run++;
      else rd_run = 0;
      if (rd_run > rd_run_max) rd_run_max = rd_run;
      if (inject_req != inject_ack) begin
        inject_ack++;
        bus.mem_valid_out = 1'b1;
      end
    end
  end

  // Response scoreboard: compare on the cycle a handshake will happen.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && bus.rsp_valid && bus.rsp_ready) begin
        if (sb.size() == 0) begin
          chk("rsp_unexpected", sb.size(), 1);
        end else begin
          e = sb.pop_front();
          chk("rsp_rdata", bus.rsp_rdata, e.rdata);
          chk("rsp_last", bus.rsp_last, e.last);
          chk("rsp_err", bus.rsp_err, e.err);
        end
      end
    end
  end

  task automatic send_cmd(input logic wr, input logic [31:0] addr, input logic [3:0] len);
    bus.cmd_wr    = wr;
    bus.cmd_addr  = addr;
    bus.cmd_len   = len;
    bus.cmd_valid = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (bus.cmd_ready) break;
    end
    chk("cmd_accept", bus.cmd_ready, 1);
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic send_wdata(input logic [31:0] d);
    bus.wdata       = d;
    bus.wdata_valid = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (bus.wdata_ready) break;
    end
    chk("wdata_accept", bus.wdata_ready, 1);
    @(posedge clk);
    #1;
    bus.wdata_valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (sb.size() == 0 && bus.cmd_ready) break;
    end
    chk("drain", (sb.size() == 0 && bus.cmd_ready), 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    logic [31:0] a;
    bus.cmd_valid   = 1'b0;
    bus.cmd_wr      = 1'b0;
    bus.cmd_addr    = '0;
    bus.cmd_len     = '0;
    bus.wdata_valid = 1'b0;
    bus.wdata       = '0;
    bus.rsp_ready   = 1'b1;
    rst             = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", bus.cmd_ready, 0);
    chk("rst_wdata_ready", bus.wdata_ready, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_stray", bus.stray_err, 0);
    chk("rst_mem_en", bus.mem_en, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Single-beat write at address 3
    clear_log();
    push_exp(32'h0, 1'b1, 1'b0);
    send_cmd(1'b1, 32'd3, 4'd0);
    send_wdata(32'hA5A5_0001);
    drain();
    chk("wr_log_n", log_addr.size(), 1);
    chk("wr_log_wr", log_wr[0], 1);
    chk("wr_log_addr", log_addr[0], 3);
    chk("wr_log_data", log_data[0], 32'hA5A5_0001);
    chk("wr_mem3", mem_model[3], 32'hA5A5_0001);

    // Read burst wrapping past DEPTH-1
    clear_log();
    for (int b = 0; b < 4; b++) begin
      a = 32'((14 + b) % DEPTH);
      push_exp(32'hD000_0000 | a, (b == 3), 1'b0);
    end
    send_cmd(1'b0, 32'd14, 4'd3);
    drain();
    chk("rdb_log_n", log_addr.size(), 4);
    for (int b = 0; b < 4; b++) begin
      if (b < log_addr.size()) begin
        chk("rdb_addr", log_addr[b], 32'((14 + b) % DEPTH));
        chk("rdb_wr", log_wr[b], 0);
      end
    end

    // Read timeout, burst aborted after first beat
    clear_log();
    mute = 1'b1;
    push_exp(32'h0, 1'b1, 1'b1);
    send_cmd(1'b0, 32'd5, 4'd2);
    for (k = 1; k <= 100; k++) begin
      @(posedge clk);
      #1;
      if (bus.rsp_valid) break;
    end
    chk("tmo_cycles", k, TIMEOUT + 1);
    drain();
    mute = 1'b0;
    chk("tmo_log_n", log_addr.size(), 1);

    // Out-of-range start address
    clear_log();
    push_exp(32'h0, 1'b1, 1'b1);
    send_cmd(1'b0, 32'd16, 4'd0);
    drain();
    chk("oor_log_n", log_addr.size(), 0);
    @(negedge clk);
    chk("oor_cmd_ready", bus.cmd_ready, 1);
    @(posedge clk);
    #1;

    // Response backpressure on a 2-beat read
    clear_log();
    bus.rsp_ready = 1'b0;
    push_exp(32'hD000_0007, 1'b0, 1'b0);
    push_exp(32'hD000_0008, 1'b1, 1'b0);
    send_cmd(1'b0, 32'd7, 4'd1);
    for (k = 0; k < 100; k++) begin
      @(posedge clk);
      #1;
      if (bus.rsp_valid) break;
    end
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      chk("bp_valid", bus.rsp_valid, 1);
      chk("bp_rdata", bus.rsp_rdata, 32'hD000_0007);
      chk("bp_last", bus.rsp_last, 0);
      chk("bp_log_n", log_addr.size(), 1);
    end
    bus.rsp_ready = 1'b1;
    drain();
    chk("bp_log_n_end", log_addr.size(), 2);

    // Reset in the middle of a long write burst, then a stray valid in IDLE
    clear_log();
    send_cmd(1'b1, 32'd0, 4'd7);
    send_wdata(32'h1111_0000);
    send_wdata(32'h1111_0001);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mrst_flags", {bus.cmd_ready, bus.wdata_ready, bus.rsp_valid, bus.rsp_last,
                       bus.rsp_err, bus.stray_err, bus.mem_en, bus.mem_wr}, 0);
    chk("mrst_mem_addr", bus.mem_addr, 0);
    chk("mrst_mem_data", bus.mem_data_in, 0);
    chk("mrst_rdata", bus.rsp_rdata, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    inject_req++;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("stray_set", bus.stray_err, 1);
    chk("stray_no_rsp", bus.rsp_valid, 0);
    chk("stray_wdata_ready", bus.wdata_ready, 0);
    chk("mrst_log_n", log_addr.size(), 2);
    @(posedge clk);
    #1;

    // Beats written before the reset landed in memory
    push_exp(32'h1111_0000, 1'b0, 1'b0);
    push_exp(32'h1111_0001, 1'b1, 1'b0);
    send_cmd(1'b0, 32'd0, 4'd1);
    drain();
    chk("stray_sticky", bus.stray_err, 1);

    chk("sb_empty", sb.size(), 0);
    chk("rd_strobe_width", rd_run_max, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
